// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR pattern generator and its checker.
// lfsr_next() is the single source of truth for the feedback polynomial.
package lfsr_pkg;

   localparam int LFSR_W = 8;

   localparam int TAP_A = 7;
   localparam int TAP_B = 5;
   localparam int TAP_C = 4;
   localparam int TAP_D = 2;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   // Shift toward the MSB, feedback enters at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. clr and inc together load 1, which restarts a count
// in the same cycle the old value is consumed.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] base;

   always_comb begin
      base  = clr_i ? '0 : cnt_q;
      cnt_d = base;
      if (inc_i && (base != {W{1'b1}})) begin
         cnt_d = base + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for the 8-bit LFSR pattern stream: lock detection,
// error counting, stuck-at-zero detection and sequence-period measurement.
module lfsr_stream_checker
   import lfsr_pkg::*;
#(
   parameter int SYNC_LEN    = 3,
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16,
   parameter int PER_W       = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clear,
   input  logic [LFSR_W-1:0] din,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [PER_W-1:0]  period,
   output logic              period_valid,
   output logic              stuck_zero
);

   localparam int MW = $clog2(SYNC_LEN + 1);
   localparam int XW = $clog2(LOSS_THRESH + 1);
   localparam logic [MW-1:0] SYNC_TGT = MW'(SYNC_LEN);
   localparam logic [XW-1:0] LOSS_TGT = XW'(LOSS_THRESH);

   chk_state_e        state_q, state_d;
   logic [LFSR_W-1:0] prev_q, prev_d;
   logic [LFSR_W-1:0] ref_q, ref_d;
   logic [MW-1:0]     match_cnt_q, match_cnt_d;
   logic [XW-1:0]     miss_cnt_q, miss_cnt_d;
   logic [PER_W-1:0]  period_q, period_d;
   logic              period_valid_q, period_valid_d;
   logic              err_pulse_q, err_pulse_d;
   logic              stuck_zero_q, stuck_zero_d;

   logic [LFSR_W-1:0] pred;
   logic              mismatch;
   logic [MW-1:0]     match_inc;
   logic [XW-1:0]     miss_inc;
   logic              err_clr, err_inc;
   logic              per_clr, per_inc;
   logic [PER_W-1:0]  per_cnt;

   assign pred      = lfsr_next(prev_q);
   assign mismatch  = (din != pred);
   assign match_inc = match_cnt_q + MW'(1);
   assign miss_inc  = miss_cnt_q + XW'(1);

   always_comb begin
      state_d        = state_q;
      prev_d         = prev_q;
      ref_d          = ref_q;
      match_cnt_d    = match_cnt_q;
      miss_cnt_d     = miss_cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      err_pulse_d    = 1'b0;
      stuck_zero_d   = stuck_zero_q;
      err_clr        = 1'b0;
      err_inc        = 1'b0;
      per_clr        = 1'b0;
      per_inc        = 1'b0;

      if (clear) begin
         state_d      = HUNT;
         match_cnt_d  = '0;
         miss_cnt_d   = '0;
         period_d     = '0;
         stuck_zero_d = 1'b0;
         err_clr      = 1'b0 | 1'b1;
         per_clr      = 1'b1;
      end else if (en) begin
         prev_d = din;
         unique case (state_q)
            HUNT: begin
               state_d     = SYNC;
               match_cnt_d = '0;
            end
            SYNC: begin
               if (mismatch) begin
                  match_cnt_d = '0;
               end else if (match_inc == SYNC_TGT) begin
                  state_d     = LOCKED;
                  ref_d       = din;
                  match_cnt_d = '0;
                  miss_cnt_d  = '0;
                  per_clr     = 1'b1;
                  per_inc     = 1'b1;
               end else begin
                  match_cnt_d = match_inc;
               end
            end
            LOCKED: begin
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  if (miss_inc == LOSS_TGT) begin
                     state_d     = SYNC;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     miss_cnt_d = miss_inc;
                  end
               end else begin
                  miss_cnt_d = '0;
               end
               // Reference recurrence closes one period and restarts the count at 1.
               per_inc = 1'b1;
               if ((din == ref_q) && (per_cnt != '0)) begin
                  period_d       = per_cnt;
                  period_valid_d = 1'b1;
                  per_clr        = 1'b1;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase

         // An all-zero sample predicts itself, so it must never be allowed to lock.
         if (din == '0) begin
            stuck_zero_d = 1'b1;
            state_d      = HUNT;
            match_cnt_d  = '0;
            miss_cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= HUNT;
         prev_q         <= '0;
         ref_q          <= '0;
         match_cnt_q    <= '0;
         miss_cnt_q     <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         err_pulse_q    <= 1'b0;
         stuck_zero_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         prev_q         <= prev_d;
         ref_q          <= ref_d;
         match_cnt_q    <= match_cnt_d;
         miss_cnt_q     <= miss_cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         err_pulse_q    <= err_pulse_d;
         stuck_zero_q   <= stuck_zero_d;
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (err_clr),
      .inc_i (err_inc),
      .cnt_o (err_cnt)
   );

   sat_counter #(.W(PER_W)) u_per_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (per_clr),
      .inc_i (per_inc),
      .cnt_o (per_cnt)
   );

   assign locked       = (state_q == LOCKED);
   assign err_pulse    = err_pulse_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign stuck_zero   = stuck_zero_q;

endmodule
